// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter: stages source flits in a small FIFO and
// launches them onto a valid/data link only while downstream credits remain.
module noc_credit_tx #(
  parameter int DATA_W     = 16,
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           src_valid_i,
  input  logic [DATA_W-1:0]              src_data_i,
  output logic                           src_ready_o,
  output logic                           valid_o,
  output logic [DATA_W-1:0]              data_o,
  input  logic                           credit_i,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt_o,
  output logic                           credit_err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);
  localparam logic [OW-1:0] OCC_MAX = OW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;
  logic [CW-1:0]     credit_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              launch;

  // Source handshake: a flit transfers on any rising edge where src_valid_i
  // and src_ready_o are both high; src_ready_o depends only on FIFO fullness.
  assign fifo_full    = (occ == OCC_MAX);
  assign fifo_empty   = (occ == '0);
  assign src_ready_o  = !fifo_full;
  assign push         = src_valid_i && !fifo_full;
  assign launch       = !fifo_empty && (credit_cnt != '0);
  assign credit_cnt_o = credit_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= src_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, launch})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Link register: data_o keeps the last launched flit while valid_o is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= launch;
      if (launch) begin
        data_o <= mem[rd_ptr];
      end
    end
  end

  // A return that would push the count past CREDITS is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt   <= CNT_MAX;
      credit_err_o <= 1'b0;
    end else if (launch && !credit_i) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (!launch && credit_i) begin
      if (credit_cnt == CNT_MAX) begin
        credit_err_o <= 1'b1;
      end else begin
        credit_cnt <= credit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_credit_tx.sv
// Bench for noc_credit_tx: per-cycle vector table plus a link-side scoreboard
// that checks flit order against what the source pushed.
module tb_noc_credit_tx;

  localparam int DATA_W = 16;

  typedef struct {
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              credit;
    logic              rdy;      // expected src_ready_o before the edge
    logic              valid;    // expected outputs after the edge
    logic [DATA_W-1:0] data;
    logic [2:0]        cnt;
    logic              err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              src_valid_i = 1'b0;
  logic [DATA_W-1:0] src_data_i = '0;
  logic              src_ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              credit_i = 1'b0;
  logic [2:0]        credit_cnt_o;
  logic              credit_err_o;

  logic [DATA_W-1:0] exp_q[$];
  vec_t              vecs[$];
  int                n_checks = 0;
  int                n_fail = 0;

  noc_credit_tx #(.DATA_W(DATA_W), .CREDITS(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid_i  (src_valid_i),
    .src_data_i   (src_data_i),
    .src_ready_o  (src_ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .credit_i     (credit_i),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic sv, input logic [15:0] sd, input logic cr,
                              input logic rdy, input logic v, input logic [15:0] d,
                              input logic [2:0] c, input logic e);
    vec_t t;
    t.s_valid = sv; t.s_data = sd; t.credit = cr; t.rdy = rdy;
    t.valid = v; t.data = d; t.cnt = c; t.err = e;
    vecs.push_back(t);
  endfunction

  // Driver: apply one cycle of inputs, check ready before the edge and the
  // registered outputs just after it.
  task automatic step(input vec_t v, input string tag);
    src_valid_i = v.s_valid;
    src_data_i  = v.s_data;
    credit_i    = v.credit;
    #1;
    check($sformatf("%s ready", tag), {31'd0, src_ready_o}, {31'd0, v.rdy});
    if (v.s_valid && v.rdy) exp_q.push_back(v.s_data);
    @(posedge clk);
    #1;
    src_valid_i = 1'b0;
    credit_i    = 1'b0;
    check($sformatf("%s valid", tag), {31'd0, valid_o}, {31'd0, v.valid});
    check($sformatf("%s data", tag), {16'd0, data_o}, {16'd0, v.data});
    check($sformatf("%s cnt", tag), {29'd0, credit_cnt_o}, {29'd0, v.cnt});
    check($sformatf("%s err", tag), {31'd0, credit_err_o}, {31'd0, v.err});
  endtask

  task automatic step_v(input logic sv, input logic [15:0] sd, input logic cr,
                        input logic rdy, input logic v, input logic [15:0] d,
                        input logic [2:0] c, input logic e, input string tag);
    vec_t t;
    t.s_valid = sv; t.s_data = sd; t.credit = cr; t.rdy = rdy;
    t.valid = v; t.data = d; t.cnt = c; t.err = e;
    step(t, tag);
  endtask

  // Scoreboard: every flit seen on the link must be the oldest pushed one.
  always @(negedge clk) begin
    if (rst && valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got flit 0x%0h, required none", data_o);
      end else begin
        check("sb_order", {16'd0, data_o}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Burst with no credit return
    for (int n = 1; n <= 5; n++) add(1, 16'(n), 0, 1, n > 1, 16'(n > 1 ? n - 1 : 0), 3'(5 - n > 3 ? 4 : 5 - n), 0);
    add(1, 16'h0006, 0, 1, 0, 16'h0004, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h0004, 0, 0);
    // Credit release, one flit per pulse
    add(0, 16'h0000, 1, 1, 0, 16'h0004, 1, 0);
    add(0, 16'h0000, 0, 1, 1, 16'h0005, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h0005, 0, 0);
    add(0, 16'h0000, 1, 1, 0, 16'h0005, 1, 0);
    add(0, 16'h0000, 0, 1, 1, 16'h0006, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h0006, 0, 0);
    // Steady stream with a credit every cycle
    add(1, 16'hA000, 1, 1, 0, 16'h0006, 1, 0);
    for (int n = 1; n <= 4; n++) add(1, 16'(16'hA000 + n), 1, 1, 1, 16'(16'hA000 + n - 1), 1, 0);
    add(0, 16'h0000, 0, 1, 1, 16'hA004, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'hA004, 0, 0);
    // Full FIFO with credits at zero, 0xBEEF held back
    for (int n = 1; n <= 4; n++) add(1, 16'(16'hB000 + n), 0, 1, 0, 16'hA004, 0, 0);
    add(1, 16'hBEEF, 0, 0, 0, 16'hA004, 0, 0);
    add(1, 16'hBEEF, 1, 0, 0, 16'hA004, 1, 0);
    add(1, 16'hBEEF, 0, 0, 1, 16'hB001, 0, 0);
    add(1, 16'hBEEF, 0, 1, 0, 16'hB001, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'hB001, 1, 0);
    add(0, 16'h0000, 1, 0, 1, 16'hB002, 1, 0);
    add(0, 16'h0000, 1, 1, 1, 16'hB003, 1, 0);
    add(0, 16'h0000, 1, 1, 1, 16'hB004, 1, 0);
    add(0, 16'h0000, 1, 1, 1, 16'hBEEF, 1, 0);
    // Refill credits, then overflow
    add(0, 16'h0000, 1, 1, 0, 16'hBEEF, 2, 0);
    add(0, 16'h0000, 1, 1, 0, 16'hBEEF, 3, 0);
    add(0, 16'h0000, 1, 1, 0, 16'hBEEF, 4, 0);
    add(0, 16'h0000, 1, 1, 0, 16'hBEEF, 4, 1);
    add(0, 16'h0000, 0, 1, 0, 16'hBEEF, 4, 1);
    add(0, 16'h0000, 1, 1, 0, 16'hBEEF, 4, 1);

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_low", {31'd0, valid_o}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst valid", {31'd0, valid_o}, 32'd0);
    check("rst data", {16'd0, data_o}, 32'd0);
    check("rst cnt", {29'd0, credit_cnt_o}, 32'd4);
    check("rst ready", {31'd0, src_ready_o}, 32'd1);
    check("rst err", {31'd0, credit_err_o}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-stream: valid_o must drop without waiting for a clock edge
    step_v(1, 16'hC001, 0, 1, 0, 16'hBEEF, 4, 1, "mid0");
    step_v(1, 16'hC002, 0, 1, 1, 16'hC001, 3, 1, "mid1");
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst data", {16'd0, data_o}, 32'd0);
    check("mid_rst cnt", {29'd0, credit_cnt_o}, 32'd4);
    check("mid_rst err", {31'd0, credit_err_o}, 32'd0);
    check("mid_rst ready", {31'd0, src_ready_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    // Queued flits are gone; a credit at full count with a launch is legal
    step_v(1, 16'hD001, 0, 1, 0, 16'h0000, 4, 0, "post0");
    step_v(0, 16'h0000, 1, 1, 1, 16'hD001, 4, 0, "post1");
    step_v(0, 16'h0000, 0, 1, 0, 16'hD001, 4, 0, "post2");

    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_credit_tx.md
Name: noc_credit_tx

Overview:
- Upstream transmitter for one NoC router input port; the sending end of the valid/data/credit link a router port receives.
- Accepts 16-bit flits from a local source (IP core or upstream output stage) into a small FIFO.
- Launches flits onto the link only while downstream credits remain, and replenishes credits from the router's credit return pulses.
- Sits in the network interface, driving a router's valid_i/data_i and consuming its credit_o.

Parameters:
- DATA_W, 16, flit width in bits.
- CREDITS, 4, downstream input buffer depth; also the credit counter reset value and its maximum.
- FIFO_DEPTH, 4, local staging FIFO depth in flits; power of two, >= 2.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- src_valid_i  input  1  source has a flit on src_data_i.
- src_data_i  input  DATA_W  source flit.
- src_ready_o  output  1  FIFO can accept; a push occurs when src_valid_i && src_ready_o.
- valid_o  output  1  link flit valid, one cycle per flit; connects to router valid_i.
- data_o  output  DATA_W  link flit; connects to router data_i.
- credit_i  input  1  one-cycle pulse, one freed downstream slot; from router credit_o.
- credit_cnt_o  output  $clog2(CREDITS+1)  current credit count.
- credit_err_o  output  1  sticky: a credit was returned while the count was already CREDITS.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; valid_o=0, data_o=0.
  - credit_cnt_o=CREDITS, credit_err_o=0.
  - src_ready_o=1 (combinational !full).
- Push: src_valid_i && src_ready_o at an edge writes src_data_i to the FIFO tail.
  - src_ready_o is combinational = !full and must not depend on src_valid_i.
- Launch: launch = !fifo_empty && (credit_cnt > 0), evaluated combinationally each cycle.
  - On an edge with launch=1: head is popped, data_o <= head, valid_o <= 1.
  - On an edge with launch=0: valid_o <= 0 and data_o holds its last value.
- Latency: a flit pushed at edge N into an empty FIFO with credits appears on valid_o/data_o after edge N+1.
  - Sustained throughput is 1 flit/cycle while credits and FIFO contents last.
  - No bypass path from source to link.
- Credit counter: cnt_next = cnt - launch + credit_i.
  - Launch and credit_i in the same cycle leave the count unchanged.
  - cnt==0 with credit_i: no launch that cycle; count becomes 1; launch is possible the next cycle.
  - cnt==CREDITS, credit_i, no launch: count stays CREDITS and credit_err_o <= 1 (sticky until reset).
  - cnt==CREDITS with credit_i and launch: count unchanged, no error.
- FIFO:
  - Simultaneous push and pop while not full: both occur; occupancy unchanged.
  - When full, src_ready_o=0, so push and pop cannot coincide at full.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a DEPTH+1-wide occupancy count or an extra pointer bit.
- Ordering: flits leave in exactly the order they were pushed; none dropped or duplicated.
- Reset mid-stream:
  - Queued flits are discarded.
  - The credit count returns to CREDITS, since the downstream router resets with the same rst.
  - valid_o drops immediately (asynchronous).

Test Plan:
- Reset then idle: rst low 3 cycles, release -> valid_o=0, data_o=0, credit_cnt_o=4, src_ready_o=1, credit_err_o=0.
- Burst with no credit return: push 0x0001..0x0006 back-to-back.
  - valid_o is high for 4 consecutive cycles carrying 0x0001..0x0004, then low.
  - credit_cnt_o=0, FIFO holds 0x0005/0x0006, src_ready_o=1.
- Credit release: from the previous state, pulse credit_i once -> exactly one flit 0x0005 launched the next cycle; credit_cnt_o back to 0. A second pulse launches 0x0006.
- Steady stream: credit_i pulsed every cycle while the source streams 0xA000+n.
  - valid_o is continuous, credit_cnt_o stays constant, data_o increments by 1 each cycle.
- Full FIFO: credits held at 0, push 4 flits -> src_ready_o=0. A 5th flit 0xBEEF held on src_valid_i is not accepted until a credit_i pulse frees a slot; it is then output in order.
- Credit overflow: with count=4 and FIFO empty, pulse credit_i -> credit_cnt_o stays 4, credit_err_o=1 and remains 1 until rst.
